// File: rtl/phase_scheduler.sv
// Phase dwell timer and request scheduler for the intersection light FSM.
// Emits a one-cycle advance pulse and waits for the FSM to acknowledge it by changing phase.
module phase_scheduler #(
  parameter int CNT_W       = 8,
  parameter int TICK_DIV    = 50,
  parameter int T_MIN_GREEN = 5,
  parameter int T_MAX_GREEN = 20,
  parameter int T_YELLOW    = 3,
  parameter int T_RED       = 2,
  parameter int T_LEFT      = 4,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [2:0]       phase_in,
  input  logic             req_n,
  input  logic             req_e,
  input  logic             emerg,
  output logic             advance,
  output logic [CNT_W-1:0] timer_out,
  output logic             pend_n,
  output logic             pend_e,
  output logic             fault
);

  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AK_W = $clog2(ACK_TIMEOUT + 1);

  // Handshake: advance is high for one cycle; the FSM acknowledges by changing
  // phase_in away from the phase held at pulse time. There is no re-issue.
  typedef enum logic [1:0] {IDLE, TIMING, ADVANCE, WAIT_ACK} state_t;

  state_t           state, state_nx;
  logic [PS_W-1:0]  presc, presc_nx;
  logic [2:0]       phase_prev, phase_prev_nx;
  logic [AK_W-1:0]  ack_cnt, ack_cnt_nx;
  logic [CNT_W-1:0] timer_nx;
  logic             advance_nx, pend_n_nx, pend_e_nx, fault_nx;
  logic             load, tick, phase_chg, min_ok, adv_cond;

  function automatic logic [CNT_W-1:0] duration(input logic [2:0] ph);
    case (ph)
      3'd0, 3'd4: duration = CNT_W'(T_MAX_GREEN);
      3'd1, 3'd5: duration = CNT_W'(T_YELLOW);
      3'd2, 3'd6: duration = CNT_W'(T_RED);
      default:    duration = CNT_W'(T_LEFT);
    endcase
  endfunction

  always_comb begin
    phase_chg = (phase_in != phase_prev);
    tick      = (presc == PS_W'(TICK_DIV - 1));
    min_ok    = (timer_out <= CNT_W'(T_MAX_GREEN - T_MIN_GREEN));
    // Only green phases can be cut short; emergency cannot shorten clearance phases.
    case (phase_prev)
      3'd0:    adv_cond = (timer_out == '0) || (min_ok && (pend_e || emerg));
      3'd4:    adv_cond = (timer_out == '0) || (min_ok && (pend_n || emerg));
      default: adv_cond = (timer_out == '0);
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      advance    <= 1'b0;
      timer_out  <= '0;
      pend_n     <= 1'b0;
      pend_e     <= 1'b0;
      fault      <= 1'b0;
      presc      <= '0;
      phase_prev <= 3'd0;
      ack_cnt    <= '0;
    end else begin
      state      <= state_nx;
      advance    <= advance_nx;
      timer_out  <= timer_nx;
      pend_n     <= pend_n_nx;
      pend_e     <= pend_e_nx;
      fault      <= fault_nx;
      presc      <= presc_nx;
      phase_prev <= phase_prev_nx;
      ack_cnt    <= ack_cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE: begin
        load     = 1'b1;
        state_nx = TIMING;
      end
      TIMING: begin
        if (phase_chg) load = 1'b1;
        else if (adv_cond) state_nx = ADVANCE;
      end
      ADVANCE: state_nx = WAIT_ACK;
      WAIT_ACK: begin
        if (phase_chg) begin
          load     = 1'b1;
          state_nx = TIMING;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    advance_nx    = (state_nx == ADVANCE) && (state == TIMING);
    timer_nx      = timer_out;
    presc_nx      = presc;
    phase_prev_nx = phase_prev;
    ack_cnt_nx    = ack_cnt;
    fault_nx      = fault;
    pend_n_nx     = pend_n | req_n;
    pend_e_nx     = pend_e | req_e;

    if (load) begin
      timer_nx      = duration(phase_in);
      presc_nx      = '0;
      phase_prev_nx = phase_in;
      if (phase_in == 3'd0) pend_n_nx = 1'b0;
      if (phase_in == 3'd4) pend_e_nx = 1'b0;
    end else if (state == TIMING) begin
      if (tick) begin
        presc_nx = '0;
        if (timer_out != '0) timer_nx = timer_out - 1'b1;
      end else begin
        presc_nx = presc + 1'b1;
      end
    end

    // ack_cnt counts cycles since the pulse edge; it saturates so fault is set once.
    if (advance_nx) begin
      ack_cnt_nx = '0;
    end else if ((state == ADVANCE || state == WAIT_ACK) && ack_cnt != AK_W'(ACK_TIMEOUT)) begin
      ack_cnt_nx = ack_cnt + 1'b1;
    end
    if (state == WAIT_ACK && !phase_chg && ack_cnt == AK_W'(ACK_TIMEOUT - 1))
      fault_nx = 1'b1;
  end

endmodule

// File: tb/tb_phase_scheduler.sv
// Bench for phase_scheduler: directed scenarios plus randomized phase sequences,
// checked against an arithmetic model of dwell, actuation and request latching.
module tb_phase_scheduler;

  localparam int CNT_W = 8;
  localparam int TD    = 2;
  localparam int T_MIN = 2;
  localparam int T_MAX = 6;
  localparam int T_YEL = 3;
  localparam int T_RED = 2;
  localparam int T_LFT = 4;
  localparam int ACK_T = 8;

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [2:0]       phase_in = 3'd0;
  logic             req_n = 1'b0, req_e = 1'b0, emerg = 1'b0;
  logic             advance, pend_n, pend_e, fault;
  logic [CNT_W-1:0] timer_out;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int last_adv_cyc = 0;
  logic m_pend_n = 1'b0, m_pend_e = 1'b0;
  logic [2:0] cur_phase = 3'd0;

  phase_scheduler #(
    .CNT_W(CNT_W), .TICK_DIV(TD), .T_MIN_GREEN(T_MIN), .T_MAX_GREEN(T_MAX),
    .T_YELLOW(T_YEL), .T_RED(T_RED), .T_LEFT(T_LFT), .ACK_TIMEOUT(ACK_T)
  ) dut (
    .clk(clk), .resetn(resetn), .phase_in(phase_in), .req_n(req_n), .req_e(req_e),
    .emerg(emerg), .advance(advance), .timer_out(timer_out), .pend_n(pend_n),
    .pend_e(pend_e), .fault(fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int dur(input logic [2:0] ph);
    case (ph)
      3'd0, 3'd4: return T_MAX;
      3'd1, 3'd5: return T_YEL;
      3'd2, 3'd6: return T_RED;
      default:    return T_LFT;
    endcase
  endfunction

  // Called at a negedge; the load edge is the next posedge. rn_at/re_at give the
  // cycle offset (-1 = the load edge itself) at which a one-cycle request is sampled.
  task automatic drive_phase(input logic [2:0] ph, input int rn_at, input int re_at,
                             input logic em, input int stop_at, output int adv_k);
    int d, a, s, r, exp_t;
    logic exp_a;
    d = dur(ph);
    phase_in = ph;
    emerg = em;
    req_n = (rn_at == -1);
    req_e = (re_at == -1);
    if (ph == 3'd0) m_pend_n = 1'b0; else if (req_n) m_pend_n = 1'b1;
    if (ph == 3'd4) m_pend_e = 1'b0; else if (req_e) m_pend_e = 1'b1;
    if (ph == 3'd0 || ph == 3'd4) begin
      r = (ph == 3'd0) ? re_at : rn_at;
      if (((ph == 3'd0) ? m_pend_e : m_pend_n) || em) s = 0;
      else if (r >= 0) s = r + 1;
      else s = 1 << 20;
      a = ((s > T_MIN * TD) ? s : T_MIN * TD) + 1;
      if (a > d * TD + 1) a = d * TD + 1;
    end else begin
      a = d * TD + 1;
    end
    adv_k = -1;
    cur_phase = ph;
    for (int k = 0; k <= a; k++) begin
      @(negedge clk);
      if (k < a) begin
        exp_t = d - k / TD;
        tests_run++;
        if (timer_out !== CNT_W'(exp_t)) begin
          tests_failed++;
          $display("FAIL timer ph=%0d k=%0d got %0d exp %0d", ph, k, timer_out, exp_t);
        end
      end
      tests_run++;
      if (pend_n !== m_pend_n || pend_e !== m_pend_e) begin
        tests_failed++;
        $display("FAIL pend ph=%0d k=%0d got n=%b e=%b exp n=%b e=%b",
                 ph, k, pend_n, pend_e, m_pend_n, m_pend_e);
      end
      exp_a = (k == a);
      tests_run++;
      if (advance !== exp_a) begin
        tests_failed++;
        $display("FAIL advance ph=%0d k=%0d got %b exp %b", ph, k, advance, exp_a);
      end
      if (advance === 1'b1) begin
        adv_k = k;
        last_adv_cyc = cyc;
      end
      if (k == stop_at) return;
      if (advance === 1'b1) break;
      req_n = (k == rn_at);
      req_e = (k == re_at);
      if (req_n) m_pend_n = 1'b1;
      if (req_e) m_pend_e = 1'b1;
    end
    req_n = 1'b0;
    req_e = 1'b0;
    @(negedge clk);
    tests_run++;
    if (advance !== 1'b0 || fault !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_pulse ph=%0d got adv=%b fault=%b exp 0 0", ph, advance, fault);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({advance, timer_out, pend_n, pend_e, fault} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state got adv=%b t=%0d pn=%b pe=%b f=%b exp all 0",
               advance, timer_out, pend_n, pend_e, fault);
    end
    m_pend_n = 1'b0;
    m_pend_e = 1'b0;
  endtask

  task automatic test_fixed();
    int k;
    resetn = 1'b1;
    drive_phase(3'd1, -2, -2, 1'b0, -1, k);
    tests_run++;
    if (k !== 7) begin
      tests_failed++;
      $display("FAIL fixed_yellow_latency got %0d exp 7", k);
    end
  endtask

  task automatic test_max_green();
    int k;
    drive_phase(3'd0, -2, -2, 1'b0, -1, k);
    tests_run++;
    if (k !== 13 || pend_e !== 1'b0) begin
      tests_failed++;
      $display("FAIL max_green got k=%0d pend_e=%b exp 13 0", k, pend_e);
    end
  endtask

  task automatic test_actuated();
    int k;
    drive_phase(3'd3, -2, -2, 1'b0, -1, k);
    drive_phase(3'd0, -2, 1, 1'b0, -1, k);
    tests_run++;
    if (k !== 5 || pend_e !== 1'b1) begin
      tests_failed++;
      $display("FAIL actuated_green got k=%0d pend_e=%b exp 5 1", k, pend_e);
    end
  endtask

  task automatic test_emergency();
    int k;
    drive_phase(3'd5, -2, -2, 1'b1, -1, k);
    tests_run++;
    if (k !== 7) begin
      tests_failed++;
      $display("FAIL emerg_yellow got %0d exp 7", k);
    end
    drive_phase(3'd4, -2, -2, 1'b1, -1, k);
    tests_run++;
    if (k !== 5) begin
      tests_failed++;
      $display("FAIL emerg_green got %0d exp 5", k);
    end
    emerg = 1'b0;
  endtask

  task automatic test_collision();
    int k;
    drive_phase(3'd7, 1, -2, 1'b0, -1, k);
    tests_run++;
    if (pend_n !== 1'b1) begin
      tests_failed++;
      $display("FAIL collision_pre got pend_n=%b exp 1", pend_n);
    end
    drive_phase(3'd0, -1, -2, 1'b0, -1, k);
    tests_run++;
    if (pend_n !== 1'b0 || k !== 13) begin
      tests_failed++;
      $display("FAIL collision got pend_n=%b k=%0d exp 0 13", pend_n, k);
    end
  endtask

  task automatic test_phase_jump();
    int k;
    drive_phase(3'd3, -2, -2, 1'b0, 3, k);
    drive_phase(3'd1, -2, -2, 1'b0, -1, k);
    tests_run++;
    if (k !== 7) begin
      tests_failed++;
      $display("FAIL phase_jump got %0d exp 7", k);
    end
  endtask

  task automatic test_random();
    int k;
    logic [2:0] ph;
    for (int i = 0; i < 30; i++) begin
      ph = 3'((int'(cur_phase) + 1 + int'($urandom_range(0, 6))) % 8);
      drive_phase(ph, int'($urandom_range(0, 14)) - 2, int'($urandom_range(0, 14)) - 2,
                  ($urandom_range(0, 3) == 0), -1, k);
    end
    emerg = 1'b0;
  endtask

  task automatic test_no_ack();
    int k;
    logic exp_f;
    drive_phase(3'd2, -2, -2, 1'b0, -1, k);
    for (int j = 1; j <= 11; j++) begin
      exp_f = ((cyc - last_adv_cyc) >= ACK_T);
      tests_run++;
      if (fault !== exp_f || advance !== 1'b0) begin
        tests_failed++;
        $display("FAIL no_ack j=%0d got fault=%b adv=%b exp %b 0",
                 cyc - last_adv_cyc, fault, advance, exp_f);
      end
      @(negedge clk);
    end
    #2 resetn = 1'b0;
    #1;
    tests_run++;
    if (fault !== 1'b0 || timer_out !== '0) begin
      tests_failed++;
      $display("FAIL async_reset_fault got fault=%b t=%0d exp 0 0", fault, timer_out);
    end
    m_pend_n = 1'b0;
    m_pend_e = 1'b0;
  endtask

  task automatic test_midphase_reset();
    int k;
    @(negedge clk);
    resetn = 1'b1;
    drive_phase(3'd6, 0, 0, 1'b0, 2, k);
    #2 resetn = 1'b0;
    #1;
    tests_run++;
    if ({advance, timer_out, pend_n, pend_e, fault} !== '0) begin
      tests_failed++;
      $display("FAIL midphase_reset got t=%0d pn=%b pe=%b exp 0 0 0", timer_out, pend_n, pend_e);
    end
    m_pend_n = 1'b0;
    m_pend_e = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    drive_phase(3'd5, -2, -2, 1'b0, -1, k);
    tests_run++;
    if (k !== 7) begin
      tests_failed++;
      $display("FAIL after_reset got %0d exp 7", k);
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_max_green();
    test_actuated();
    test_emergency();
    test_collision();
    test_phase_jump();
    test_random();
    test_no_ack();
    test_midphase_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
